// File: rtl/ocimem_pkg.sv
// Shared types and jdo field positions for the ociram arbiter and its JTAG command slot.
package ocimem_pkg;

   localparam int DATA_W        = 32;
   localparam int JDO_W         = 38;
   localparam int JDO_RD_FLAG   = 34;
   localparam int JDO_CLR_ERR   = 35;
   localparam int JDO_WDATA_LSB = 3;
   localparam int JDO_ADDR_LSB  = 2;

   typedef enum logic [1:0] {
      IDLE,
      AV_RD,
      JT_RD
   } state_t;

   typedef enum logic {
      GNT_JTAG,
      GNT_AVALON
   } owner_t;

endpackage

// File: rtl/bai1_nios2_gen2_0_cpu_ocimem_jtag_slot.sv
// JTAG command decode into a one-entry slot, plus MonAReg/MonDReg and the sticky overrun flag.
module bai1_nios2_gen2_0_cpu_ocimem_jtag_slot
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic              wr_done,
   input  logic              rd_done,
   input  logic [DATA_W-1:0] ram_q,
   output logic              slot_full,
   output logic              slot_wr,
   output logic [DATA_W-1:0] slot_data,
   output logic [ADDR_W-1:0] mon_a_reg,
   output logic [DATA_W-1:0] mon_d_reg,
   output logic              monitor_error
);

   logic strobe;
   logic done;
   logic busy;
   logic accept;
   logic unused_jdo;

   assign strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign done       = wr_done | rd_done;
   // A slot finishing this cycle can take a new command in the same cycle.
   assign busy       = slot_full && !done;
   assign accept     = strobe && !busy;
   assign unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_ERR+1], jdo[JDO_ADDR_LSB-1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_full     <= 1'b0;
         slot_wr       <= 1'b0;
         mon_a_reg     <= '0;
         mon_d_reg     <= '0;
         monitor_error <= 1'b0;
      end else begin
         if (done) begin
            slot_full <= 1'b0;
            mon_a_reg <= mon_a_reg + 1'b1;
         end
         if (rd_done)
            mon_d_reg <= ram_q;
         if (strobe && busy) begin
            monitor_error <= 1'b1;
         end else if (accept) begin
            if (take_action_ocimem_a) begin
               mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
               if (jdo[JDO_CLR_ERR])
                  monitor_error <= 1'b0;
               if (jdo[JDO_RD_FLAG]) begin
                  slot_full <= 1'b1;
                  slot_wr   <= 1'b0;
               end
            end else if (take_action_ocimem_b) begin
               slot_full <= 1'b1;
               slot_wr   <= 1'b1;
            end else begin
               slot_full <= 1'b1;
               slot_wr   <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && take_action_ocimem_b && !take_action_ocimem_a)
         slot_data <= jdo[JDO_WDATA_LSB +: DATA_W];
   end

endmodule

// File: rtl/bai1_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port ociram between the JTAG debug slot and Avalon.
module bai1_nios2_gen2_0_cpu_ocimem_arbiter
   import ocimem_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter bit JTAG_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   input  logic [3:0]        avs_byteenable,
   input  logic              avs_debugaccess,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wrdata,
   output logic [3:0]        ram_byteenable,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   state_t              state, state_nxt;
   owner_t              last_grant, last_grant_nxt;
   logic                slot_full, slot_wr;
   logic [DATA_W-1:0]   slot_data;
   logic [ADDR_W-1:0]   mon_a_reg;
   logic                jt_req, av_req;
   logic                grant_jt, grant_av;
   logic                jt_wr_done, jt_rd_done;
   logic [DATA_W-1:0]   readdata_q;

   bai1_nios2_gen2_0_cpu_ocimem_jtag_slot #(
      .ADDR_W (ADDR_W)
   ) u_slot (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .wr_done                 (jt_wr_done),
      .rd_done                 (jt_rd_done),
      .ram_q                   (ram_q),
      .slot_full               (slot_full),
      .slot_wr                 (slot_wr),
      .slot_data               (slot_data),
      .mon_a_reg               (mon_a_reg),
      .mon_d_reg               (MonDReg),
      .monitor_error           (monitor_error)
   );

   assign jt_req        = slot_full;
   assign av_req        = avs_read | avs_write;
   assign jt_wr_done    = grant_jt && slot_wr;
   assign jt_rd_done    = (state == JT_RD) && !reset;
   assign monitor_ready = !(slot_full || state == JT_RD);
   // Read data comes straight from the RAM in the completing cycle, then is held.
   assign avs_readdata  = (state == AV_RD) ? ram_q : readdata_q;

   always_comb begin
      state_nxt       = state;
      last_grant_nxt  = last_grant;
      grant_jt        = 1'b0;
      grant_av        = 1'b0;
      ram_addr        = avs_address;
      ram_wrdata      = avs_writedata;
      ram_byteenable  = avs_byteenable;
      ram_wren        = 1'b0;
      avs_waitrequest = 1'b1;
      if (!reset) begin
         case (state)
            IDLE: begin
               grant_jt = jt_req && (!av_req || last_grant == GNT_AVALON);
               grant_av = av_req && !grant_jt;
               if (grant_jt) begin
                  last_grant_nxt = GNT_JTAG;
                  ram_addr       = mon_a_reg;
                  ram_wrdata     = slot_data;
                  ram_byteenable = 4'hF;
                  ram_wren       = slot_wr;
                  if (!slot_wr)
                     state_nxt = JT_RD;
               end else if (grant_av) begin
                  last_grant_nxt = GNT_AVALON;
                  // A simultaneous read+write is a write; without debugaccess it completes as a no-op.
                  if (avs_write) begin
                     ram_wren        = avs_debugaccess;
                     avs_waitrequest = 1'b0;
                  end else begin
                     state_nxt = AV_RD;
                  end
               end
            end
            AV_RD: begin
               avs_waitrequest = 1'b0;
               state_nxt       = IDLE;
            end
            JT_RD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= JTAG_FIRST ? GNT_AVALON : GNT_JTAG;
         readdata_q <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         if (state == AV_RD)
            readdata_q <= ram_q;
      end
   end

endmodule

// File: tb/tb_bai1_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Directed bench: Avalon vector table, JTAG sequences, overrun, wrap, reset and fairness cases.
module tb_bai1_nios2_gen2_0_cpu_ocimem_arbiter;

   logic        clk;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_debugaccess;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wrdata;
   logic [3:0]  ram_byteenable;
   logic        ram_wren;
   logic [31:0] ram_q;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;

   logic [31:0] mem [256];
   logic        mem_init;
   int          n_cmp, n_fail;

   bai1_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8), .JTAG_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
      .avs_waitrequest(avs_waitrequest), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
      .ram_byteenable(ram_byteenable), .ram_wren(ram_wren), .ram_q(ram_q),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ociram model: byte-enabled write, registered 1-cycle read; initial word i = C0FFEE_ii
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= {24'hC0FFEE, i[7:0]};
      end else if (ram_wren) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
      end
      ram_q <= mem[ram_addr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
      logic [37:0] d;
      d = '0;
      d[9:2] = a;
      d[34]  = rd;
      d[35]  = clr;
      return d;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] data);
      logic [37:0] d;
      d = '0;
      d[34:3] = data;
      return d;
   endfunction

   // kind 0: ocimem_a, 1: ocimem_b, 2: no_action_ocimem_a; one-cycle strobe
   task automatic jt_strobe(input int kind, input logic [37:0] d);
      jdo = d;
      case (kind)
         0:       take_action_ocimem_a = 1'b1;
         1:       take_action_ocimem_b = 1'b1;
         default: take_no_action_ocimem_a = 1'b1;
      endcase
      step();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      jdo = '0;
   endtask

   task automatic wait_ready(input string name);
      int k;
      k = 0;
      while (!monitor_ready && k < 10) begin
         step();
         k++;
      end
      check(name, {31'b0, monitor_ready}, 32'd1);
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        dbg;
      logic [31:0] exp_rdata;
      logic        exp_wren;
   } av_vec_t;

   av_vec_t vec [9];

   initial begin
      int nj, na, viol, first, last, rd_bad;
      logic [31:0] prev_d;

      vec[0] = '{1'b1, 1'b0, 8'h20, 32'h5A5A5A5A, 4'b0011, 1'b1, 32'h0,        1'b1};
      vec[1] = '{1'b0, 1'b1, 8'h20, 32'h0,        4'hF,    1'b0, 32'hC0FF5A5A, 1'b0};
      vec[2] = '{1'b1, 1'b0, 8'h21, 32'h12345678, 4'hF,    1'b0, 32'h0,        1'b0};
      vec[3] = '{1'b0, 1'b1, 8'h21, 32'h0,        4'hF,    1'b0, 32'hC0FFEE21, 1'b0};
      vec[4] = '{1'b1, 1'b0, 8'h30, 32'h11223344, 4'b1100, 1'b1, 32'h0,        1'b1};
      vec[5] = '{1'b0, 1'b1, 8'h30, 32'h0,        4'hF,    1'b0, 32'h1122EE30, 1'b0};
      vec[6] = '{1'b0, 1'b1, 8'hFF, 32'h0,        4'hF,    1'b0, 32'hC0FFEEFF, 1'b0};
      vec[7] = '{1'b1, 1'b1, 8'h40, 32'hCAFEBABE, 4'hF,    1'b1, 32'h0,        1'b1};
      vec[8] = '{1'b0, 1'b1, 8'h40, 32'h0,        4'hF,    1'b0, 32'hCAFEBABE, 1'b0};

      n_cmp = 0; n_fail = 0;
      reset = 1'b1; mem_init = 1'b1; jdo = '0;
      take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
      avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
      avs_byteenable = '0; avs_debugaccess = 0;
      step(); step();
      mem_init = 1'b0; reset = 1'b0;
      #1;
      check("rst_mondreg", MonDReg, 32'h0);
      check("rst_ready", {31'b0, monitor_ready}, 32'd1);
      check("rst_error", {31'b0, monitor_error}, 32'd0);
      check("rst_waitreq", {31'b0, avs_waitrequest}, 32'd1);
      check("rst_wren", {31'b0, ram_wren}, 32'd0);
      check("rst_readdata", avs_readdata, 32'h0);
      step();

      // Avalon vector table
      for (int i = 0; i < 9; i++) begin
         avs_address = vec[i].addr; avs_write = vec[i].wr; avs_read = vec[i].rd;
         avs_writedata = vec[i].wdata; avs_byteenable = vec[i].be; avs_debugaccess = vec[i].dbg;
         #1;
         if (vec[i].wr) begin
            check($sformatf("av%0d_wr_waitreq", i), {31'b0, avs_waitrequest}, 32'd0);
            check($sformatf("av%0d_wren", i), {31'b0, ram_wren}, {31'b0, vec[i].exp_wren});
            if (vec[i].exp_wren) begin
               check($sformatf("av%0d_addr", i), {24'b0, ram_addr}, {24'b0, vec[i].addr});
               check($sformatf("av%0d_be", i), {28'b0, ram_byteenable}, {28'b0, vec[i].be});
            end
            step();
         end else begin
            check($sformatf("av%0d_rd_stall", i), {31'b0, avs_waitrequest}, 32'd1);
            step();
            check($sformatf("av%0d_rd_waitreq", i), {31'b0, avs_waitrequest}, 32'd0);
            check($sformatf("av%0d_rdata", i), avs_readdata, vec[i].exp_rdata);
         end
         avs_write = 0; avs_read = 0; avs_debugaccess = 0;
         step();
      end

      // JTAG load/write/read sequence
      jt_strobe(0, jdo_a(8'h10, 1'b0, 1'b0));
      jt_strobe(1, jdo_b(32'hDEADBEEF));
      check("jt_wr_wren", {31'b0, ram_wren}, 32'd1);
      check("jt_wr_addr", {24'b0, ram_addr}, 32'h10);
      check("jt_wr_data", ram_wrdata, 32'hDEADBEEF);
      check("jt_wr_be", {28'b0, ram_byteenable}, 32'hF);
      check("jt_wr_busy", {31'b0, monitor_ready}, 32'd0);
      step();
      check("jt_wr_free", {31'b0, monitor_ready}, 32'd1);
      jt_strobe(1, jdo_b(32'h01234567));
      step();
      jt_strobe(0, jdo_a(8'h10, 1'b1, 1'b0));
      wait_ready("jt_rd1_ready");
      check("jt_rd1_data", MonDReg, 32'hDEADBEEF);
      jt_strobe(2, '0);
      wait_ready("jt_rd2_ready");
      check("jt_rd2_data", MonDReg, 32'h01234567);
      jt_strobe(2, '0);
      wait_ready("jt_rd3_ready");
      check("jt_rd3_data", MonDReg, 32'hC0FFEE12);

      // MonAReg wrap at 0xFF
      jt_strobe(0, jdo_a(8'hFF, 1'b0, 1'b0));
      jt_strobe(1, jdo_b(32'h0BADF00D));
      check("wrap_wr_addr", {24'b0, ram_addr}, 32'hFF);
      check("wrap_wr_wren", {31'b0, ram_wren}, 32'd1);
      step();
      jt_strobe(2, '0);
      wait_ready("wrap_rd_ready");
      check("wrap_rd_data", MonDReg, 32'hC0FFEE00);
      jt_strobe(0, jdo_a(8'hFF, 1'b1, 1'b0));
      wait_ready("wrap_rb_ready");
      check("wrap_rb_data", MonDReg, 32'h0BADF00D);

      // Overrun: write strobe while a read is granted but not finished (MonAReg = 0x00)
      jt_strobe(2, '0);
      jt_strobe(1, jdo_b(32'h55555555));
      check("ovr_no_wren", {31'b0, ram_wren}, 32'd0);
      step();
      check("ovr_error", {31'b0, monitor_error}, 32'd1);
      check("ovr_ready", {31'b0, monitor_ready}, 32'd1);
      check("ovr_rd_data", MonDReg, 32'hC0FFEE00);
      step();
      check("ovr_dropped", {31'b0, ram_wren}, 32'd0);
      jt_strobe(0, jdo_a(8'h05, 1'b0, 1'b1));
      check("ovr_cleared", {31'b0, monitor_error}, 32'd0);

      // Strobe coinciding with completion is accepted
      jt_strobe(2, '0);
      step();
      jt_strobe(2, '0);
      check("coin_error", {31'b0, monitor_error}, 32'd0);
      check("coin_busy", {31'b0, monitor_ready}, 32'd0);
      check("coin_rd1", MonDReg, 32'hC0FFEE05);
      wait_ready("coin_ready");
      check("coin_rd2", MonDReg, 32'hC0FFEE06);

      // Reset while in JT_RD
      jt_strobe(2, '0);
      step();
      reset = 1'b1;
      #1;
      check("rjt_wren", {31'b0, ram_wren}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      check("rjt_mondreg", MonDReg, 32'h0);
      check("rjt_ready", {31'b0, monitor_ready}, 32'd1);
      check("rjt_waitreq", {31'b0, avs_waitrequest}, 32'd1);
      check("rjt_wren2", {31'b0, ram_wren}, 32'd0);
      avs_address = 8'h50; avs_write = 1; avs_writedata = 32'h77777777;
      avs_byteenable = 4'hF; avs_debugaccess = 0;
      #1;
      check("nodbg_waitreq", {31'b0, avs_waitrequest}, 32'd0);
      check("nodbg_wren", {31'b0, ram_wren}, 32'd0);
      step();
      avs_write = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;

      // Fairness: JTAG read and Avalon read pending continuously
      take_no_action_ocimem_a = 1'b1;
      step();
      avs_address = 8'h80; avs_read = 1'b1;
      nj = 0; na = 0; viol = 0; first = 0; last = 0; rd_bad = 0; prev_d = MonDReg;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (MonDReg != prev_d) begin
            nj++;
            if (first == 0) first = 1;
            if (last == 1) viol++;
            last = 1;
            prev_d = MonDReg;
         end
         if (avs_read && !avs_waitrequest) begin
            na++;
            if (first == 0) first = 2;
            if (last == 2) viol++;
            last = 2;
            if (avs_readdata !== 32'hC0FFEE80) rd_bad++;
         end
         step();
      end
      take_no_action_ocimem_a = 1'b0;
      avs_read = 1'b0;
      step(); step(); step();
      check("fair_first_jtag", first, 32'd1);
      check("fair_alternate", viol, 32'd0);
      check("fair_jtag_served", {31'b0, nj >= 20}, 32'd1);
      check("fair_avalon_served", {31'b0, na >= 20}, 32'd1);
      check("fair_readdata", rd_bad, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
